// File: rtl/if_prefetch_if.sv
// Bus bundle between the prefetch unit, its instruction memory port and decode.
// The prefetch unit takes the master modport; memory/decode models take slave.
interface if_prefetch_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             mem_read;
  logic [AW-1:0]    mem_address;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;
  logic             redirect;
  logic [AW-1:0]    redirect_pc;
  logic             take;
  logic             valid_out;
  logic [WIDTH-1:0] instruction;
  logic [AW-1:0]    pc_out;
  logic [CW-1:0]    count;

  modport master (
    output mem_read, mem_address, valid_out, instruction, pc_out, count,
    input  mem_resp, mem_rdata, redirect, redirect_pc, take
  );

  modport slave (
    input  mem_read, mem_address, valid_out, instruction, pc_out, count,
    output mem_resp, mem_rdata, redirect, redirect_pc, take
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch unit: one outstanding memory read, DEPTH-entry prefetch FIFO,
// redirect with flush and discard of an in-flight response.
module if_prefetch #(
  parameter int          WIDTH    = 16,
  parameter int          AW       = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic          clk,
  input  logic          reset,
  if_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    req_pc_q, req_pc_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mem_read_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    pcs_q  [DEPTH];

  logic             push_s;
  logic             pop_s;
  logic             room_s;
  logic [AW-1:0]    pc_seq_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  // FIFO bookkeeping; a redirect flush overrides any same-cycle push or pop.
  always_comb begin
    pop_s    = (count_q != CW'(0)) && bus.take;
    push_s   = (state_q == REQ) && bus.mem_resp && !bus.redirect;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (bus.redirect) begin
      head_d  = PW'(0);
      tail_d  = PW'(0);
      count_d = CW'(0);
    end else begin
      if (push_s) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
    room_s   = (count_d < CW'(DEPTH));
    pc_seq_s = fetch_pc_q + AW'(PC_STEP);
  end

  // Fetch FSM next state: a live request can never be aborted, only discarded.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (room_s) begin
          state_d  = REQ;
          req_pc_d = fetch_pc_q;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_resp && bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          req_pc_d   = bus.redirect_pc;
        end else if (bus.mem_resp) begin
          fetch_pc_d = pc_seq_s;
          if (room_s) begin
            req_pc_d = pc_seq_s;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = DISCARD;
        end else begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (bus.mem_resp) begin
          state_d  = REQ;
          req_pc_d = fetch_pc_d;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= AW'(RESET_PC);
      req_pc_q   <= AW'(RESET_PC);
      head_q     <= PW'(0);
      tail_q     <= PW'(0);
      count_q    <= CW'(0);
      mem_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_read_q <= (state_d != IDLE);
    end
  end

  // FIFO storage written at the tail on each accepted response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= WIDTH'(0);
        pcs_q[i]  <= AW'(0);
      end
    end else if (push_s) begin
      data_q[tail_q] <= bus.mem_rdata;
      pcs_q[tail_q]  <= fetch_pc_q;
    end else begin
      data_q[tail_q] <= data_q[tail_q];
      pcs_q[tail_q]  <= pcs_q[tail_q];
    end
  end

  // Outputs; the head entry reads as zero while the FIFO is empty.
  always_comb begin
    bus.mem_read    = mem_read_q;
    bus.mem_address = req_pc_q;
    bus.count       = count_q;
    bus.valid_out   = (count_q != CW'(0));
    if (count_q != CW'(0)) begin
      bus.instruction = data_q[head_q];
      bus.pc_out      = pcs_q[head_q];
    end else begin
      bus.instruction = WIDTH'(0);
      bus.pc_out      = AW'(0);
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed plus random checks of if_prefetch against a queue-based fetch model.
module tb_if_prefetch;
  localparam int WIDTH = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  ent_t        q[$];
  logic [15:0] m_fetch;
  logic [15:0] m_addr;
  bit          m_out;
  bit          m_stale;

  always #5 clk = ~clk;

  if_prefetch_if #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) bus();

  if_prefetch #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .RESET_PC(0), .PC_STEP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] memval(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch = 16'h0000;
    m_addr  = 16'h0000;
    m_out   = 1'b0;
    m_stale = 1'b0;
  endtask

  // One clock of the fetch rules: complete/drop response, flush or pop, launch.
  task automatic model_step(input bit resp, input logic [15:0] rd, input bit redir,
                            input logic [15:0] rpc, input bit tk);
    bit was_out = m_out;
    bit done    = 1'b0;
    bit pop_ok  = tk && (q.size() > 0);
    if (m_out && resp) begin
      done = 1'b1;
      if (!m_stale && !redir) begin
        q.push_back({m_addr, rd});
        m_fetch = m_addr + 16'd2;
      end
      m_out   = 1'b0;
      m_stale = 1'b0;
    end
    if (redir) begin
      q.delete();
      m_fetch = rpc;
      if (m_out) m_stale = 1'b1;
    end else if (pop_ok) begin
      void'(q.pop_front());
    end
    if ((done || (!was_out && !redir)) && (q.size() < DEPTH)) begin
      m_out  = 1'b1;
      m_addr = m_fetch;
    end
  endtask

  task automatic compare_all();
    chk("mem_read", bus.mem_read, m_out);
    if (m_out) chk("mem_address", bus.mem_address, m_addr);
    chk("valid_out", bus.valid_out, q.size() > 0);
    chk("count", bus.count, q.size());
    chk("instruction", bus.instruction, (q.size() > 0) ? q[0].data : 16'h0000);
    chk("pc_out", bus.pc_out, (q.size() > 0) ? q[0].pc : 16'h0000);
  endtask

  task automatic step(input bit resp, input bit redir, input logic [15:0] rpc, input bit tk);
    logic [15:0] rd;
    rd              = memval(m_addr);
    bus.mem_resp    = resp;
    bus.mem_rdata   = resp ? rd : 16'h0000;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.take        = tk;
    @(posedge clk);
    #1;
    model_step(resp, rd, redir, rpc, tk);
    compare_all();
    bus.mem_resp = 1'b0;
    bus.redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = 16'h0000;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.take        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    step(1'b0, 1'b0, 16'h0, 1'b1);

    // Streaming with decode always taking: one-cycle memory, count stays small.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      chk("t1_pc_out", bus.pc_out, 16'(2 * i));
      chk("t1_instr", bus.instruction, memval(16'(2 * i)));
      step(1'b0, 1'b0, 16'h0, 1'b1);
    end

    // Fill with decode stalled, then one take restarts fetch at 8.
    do_reset();
    for (int i = 0; i < 8; i++) if (m_out) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t2_count_full", bus.count, 4);
    chk("t2_idle", bus.mem_read, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t2_count_after_take", bus.count, 3);
    chk("t2_restart_addr", bus.mem_address, 16'h0008);

    // Redirect during a pending read: response is discarded.
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h3000, 1'b0);
    chk("t3_flushed", bus.count, 0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t3_addr_held", bus.mem_address, 16'h0004);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_stale_dropped", bus.valid_out, 1'b0);
    chk("t3_new_addr", bus.mem_address, 16'h3000);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_first_pc", bus.pc_out, 16'h3000);

    // Redirect coinciding with a response: no discard cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("t4_pending_8", bus.mem_address, 16'h0008);
    step(1'b1, 1'b1, 16'h1000, 1'b1);
    chk("t4_no_push", bus.count, 0);
    chk("t4_addr", bus.mem_address, 16'h1000);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t4_pc", bus.pc_out, 16'h1000);
    chk("t4_instr", bus.instruction, 16'hB5A5);

    // Repeated redirects while discarding: the newest target wins.
    do_reset();
    step(1'b0, 1'b1, 16'h1800, 1'b0);
    step(1'b0, 1'b1, 16'h2000, 1'b0);
    step(1'b0, 1'b1, 16'h4000, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_addr", bus.mem_address, 16'h4000);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_first_pc", bus.pc_out, 16'h4000);

    // Asynchronous reset mid-request, late response, then PC wrap.
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_two_queued", bus.count, 2);
    reset = 1'b1;
    #1;
    chk("t6_async_count", bus.count, 0);
    chk("t6_async_valid", bus.valid_out, 1'b0);
    chk("t6_async_read", bus.mem_read, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_late_resp", bus.count, 0);
    chk("t6_restart", bus.mem_address, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFE, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_wrap_pc", bus.pc_out, 16'hFFFE);
    chk("t6_wrap_addr", bus.mem_address, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(m_out && ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0),
           16'($urandom_range(0, 65535)) & 16'hFFFE,
           ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
